// File: rtl/sram_burst_pkg.sv
// Shared definitions for the SRAM burst master: default widths and FSM state encoding.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package sram_burst_pkg;

    localparam int ADDR_WIDTH_DFLT = 9;
    localparam int DATA_WIDTH_DFLT = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/sram_read_skid.sv
// Two-entry read-return buffer holding SRAM read beats and their last-beat tags, in order.
// Latency: a pushed beat is visible on the outputs the cycle after the push.
// Backpressure: the head entry is held stable until popped; the caller never pushes more than 2 outstanding.
module sram_read_skid
    import sram_burst_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DFLT
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  push_last_i,
    input  logic                  pop_i,
    output logic                  vld_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o,
    output logic [1:0]            count_o
);

    logic [DATA_WIDTH-1:0] mem_q [2];
    logic                  last_q [2];
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [1:0]            count_q;

    // Storage, pointers and occupancy; reset empties the buffer and zeroes the head data.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i]  <= '0;
                last_q[i] <= 1'b0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q]  <= push_data_i;
                last_q[wr_ptr_q] <= push_last_i;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    assign vld_o   = (count_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q];
    assign last_o  = vld_o & last_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/sram_burst_master.sv
// Burst master turning write/read burst commands into single-port SRAM accesses (optional macro SRAM_BURST_WRAP_EN).
// Latency: write beats hit SRAM in the handshake cycle; first read beat appears 3 cycles after the command handshake.
// Backpressure: wrValid stalls writes; rdReady low stops read issue once buffer plus in-flight reads reach 2.
module sram_burst_master
    import sram_burst_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DFLT,
    parameter int DATA_WIDTH = DATA_WIDTH_DFLT
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  cmdValid,
    output logic                  cmdReady,
    input  logic                  cmdWrite,
    input  logic [ADDR_WIDTH-1:0] cmdAddress,
    input  logic [ADDR_WIDTH-1:0] cmdLength,
    input  logic                  wrValid,
    output logic                  wrReady,
    input  logic [DATA_WIDTH-1:0] wrData,
    output logic                  rdValid,
    input  logic                  rdReady,
    output logic [DATA_WIDTH-1:0] rdData,
    output logic                  rdLast,
    output logic                  busy,
    output logic                  cmdError,
    output logic                  sramWriteEnable,
    output logic [ADDR_WIDTH-1:0] sramAddress,
    output logic [DATA_WIDTH-1:0] sramDataIn,
    input  logic [DATA_WIDTH-1:0] sramDataOut
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] left_q, left_d;
    logic [ADDR_WIDTH-1:0] last_addr_q;
    logic                  err_q, err_d;
    logic                  inflight_q;
    logic                  inflight_last_q;
    logic                  cmd_fire, wr_fire, rd_issue, rd_pop, range_bad;
    logic [1:0]            buf_count;
    logic [2:0]            credit_sum;

`ifdef SRAM_BURST_WRAP_EN
    // Addresses wrap modulo 2^ADDR_WIDTH, so every command is legal.
    assign range_bad = 1'b0;
`else
    logic [ADDR_WIDTH:0]   end_addr;
    // A burst whose last word would pass the top of the SRAM carries out of ADDR_WIDTH bits.
    assign end_addr  = {1'b0, cmdAddress} + {1'b0, cmdLength};
    assign range_bad = end_addr[ADDR_WIDTH];
`endif

    assign cmd_fire   = cmdValid & (state_q == ST_IDLE);
    assign wr_fire    = wrValid & (state_q == ST_WRITE);
    assign rd_pop     = rdValid & rdReady;
    // Slots that will be spoken for after this cycle: buffered + in flight - leaving now.
    assign credit_sum = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, rd_pop};
    assign rd_issue   = (state_q == ST_READ) && (credit_sum < 3'd2);

    // Next-state, address and beat-count logic.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        left_d  = left_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    if (range_bad) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = cmdAddress;
                        left_d  = cmdLength;
                        state_d = cmdWrite ? ST_WRITE : ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                if (wr_fire) begin
                    addr_d = addr_q + ADDR_ONE;
                    left_d = left_q - ADDR_ONE;
                    if (left_q == '0) state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (rd_issue) begin
                    addr_d = addr_q + ADDR_ONE;
                    left_d = left_q - ADDR_ONE;
                    if (left_q == '0) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if ((buf_count == 2'd0) && !inflight_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, burst pointers, error pulse and read-in-flight tracking.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q         <= ST_IDLE;
            addr_q          <= '0;
            left_q          <= '0;
            err_q           <= 1'b0;
            last_addr_q     <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            left_q          <= left_d;
            err_q           <= err_d;
            inflight_q      <= rd_issue;
            inflight_last_q <= rd_issue && (left_q == '0);
            if (wr_fire || rd_issue) last_addr_q <= addr_q;
        end
    end

    assign cmdReady        = (state_q == ST_IDLE);
    assign busy            = (state_q != ST_IDLE);
    assign wrReady         = (state_q == ST_WRITE);
    assign cmdError        = err_q;
    assign sramWriteEnable = wr_fire;
    assign sramDataIn      = wrData;
    // Present the live address only while accessing; otherwise hold the last one used.
    assign sramAddress     = (wr_fire || rd_issue) ? addr_q : last_addr_q;

    sram_read_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_read_skid (
        .clock       (clock),
        .resetN      (resetN),
        .push_i      (inflight_q),
        .push_data_i (sramDataOut),
        .push_last_i (inflight_last_q),
        .pop_i       (rd_pop),
        .vld_o       (rdValid),
        .data_o      (rdData),
        .last_o      (rdLast),
        .count_o     (buf_count)
    );

endmodule

// File: doc/sram_burst_master.md
SRAM_BURST_MASTER -- requirements
Module: sram_burst_master

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 9, SRAM word-address width; DATA_WIDTH, default 32, SRAM word width.
REQ-002 SHALL have ports:
- clock  in  1  sole clock, rising edge.
- resetN  in  1  asynchronous active-low reset.
- cmdValid  in  1  command offered.
- cmdReady  out  1  command accepted when high with cmdValid.
- cmdWrite  in  1  1=write burst, 0=read burst.
- cmdAddress  in  ADDR_WIDTH  burst start word.
- cmdLength  in  ADDR_WIDTH  beats minus one (0..511 = 1..512 beats).
- wrValid  in  1  write beat offered.
- wrReady  out  1  write beat accepted.
- wrData  in  DATA_WIDTH  write beat.
- rdValid  out  1  read beat available.
- rdReady  in  1  read beat consumed.
- rdData  out  DATA_WIDTH  read beat.
- rdLast  out  1  final beat of burst, qualified by rdValid.
- busy  out  1  state not IDLE.
- cmdError  out  1  one-cycle rejected-command pulse.
- sramWriteEnable  out  1  SRAM write strobe.
- sramAddress  out  ADDR_WIDTH  SRAM address.
- sramDataIn  out  DATA_WIDTH  SRAM write data.
- sramDataOut  in  DATA_WIDTH  SRAM read data, valid one cycle after address.

Function
REQ-003 SHALL implement states IDLE, WRITE, READ, DRAIN; cmdReady SHALL be 1 only in IDLE.
REQ-004 SHALL, on cmdValid&cmdReady, latch address and length, then enter WRITE (cmdWrite=1) or READ (cmdWrite=0).
REQ-005 SHALL in WRITE drive wrReady=1; per wrValid&wrReady, same cycle: sramWriteEnable=1, sramAddress=current, sramDataIn=wrData; address then increments.
REQ-006 SHALL leave WRITE for IDLE the cycle after the final beat handshake.
REQ-007 SHALL in READ issue one SRAM read (sramWriteEnable=0, new sramAddress) per cycle only when 2-entry read buffer occupancy plus in-flight reads, minus this cycle's pop, is below 2.
REQ-008 SHALL capture sramDataOut into the read buffer the cycle after issue; never drop or reorder beats.
REQ-009 SHALL, with rdReady held high, first assert rdValid 3 cycles after command handshake (handshake = cycle 0) and sustain one beat per cycle.
REQ-010 SHALL hold rdData/rdValid/rdLast stable while rdValid=1 and rdReady=0.
REQ-011 SHALL enter DRAIN after the final read address issues; return to IDLE when buffer empty and no read in flight.
REQ-012 SHALL assert rdLast only with the beat at position cmdLength+1.
REQ-013 SHALL keep sramWriteEnable=0 outside WRITE handshakes; sramAddress holds its last value when idle.
REQ-014 SHALL use ADDR_WIDTH-bit unsigned address arithmetic.

Reset
REQ-015 SHALL on resetN=0, immediately: state IDLE, read buffer flushed, in-flight reads discarded, rdValid=0, rdLast=0, wrReady=0, busy=0, cmdError=0, sramWriteEnable=0, sramAddress=0, rdData=0.
REQ-016 SHALL abort a burst interrupted by reset; no further SRAM writes after reset asserts; cmdReady=1 first cycle after release.

Configuration
REQ-017 SHALL, with SRAM_BURST_WRAP_EN defined, increment addresses modulo 2^ADDR_WIDTH (511 -> 0); cmdError never asserts.
REQ-018 SHALL, without SRAM_BURST_WRAP_EN, reject commands with cmdAddress+cmdLength > 2^ADDR_WIDTH-1: handshake completes, cmdError=1 the next cycle for one cycle, state stays IDLE, no SRAM access.

Structure
REQ-019 SHALL take ADDR_WIDTH/DATA_WIDTH defaults and the state enumeration from shared package sram_burst_pkg.
REQ-020 SHALL place the 2-entry read buffer in sub-module sram_read_skid.

Verification
REQ-021 Write burst addr 0x010, length 3, data 0xA0..0xA3, wrValid constant -> WE high 4 consecutive cycles, addresses 0x010..0x013; SRAM model holds data.
REQ-022 Read back addr 0x010, length 3, rdReady high -> rdValid cycles 3..6, data 0xA0..0xA3, rdLast on 0xA3 only.
REQ-023 Same read, rdReady toggled 1/0 per cycle -> 4 beats in order, none lost or duplicated, rdData stable while stalled.
REQ-024 Read addr 0x1FE, length 3: with SRAM_BURST_WRAP_EN -> addresses 0x1FE,0x1FF,0x000,0x001; without -> cmdError one cycle, no SRAM access, busy stays 0.
REQ-025 resetN low mid write burst after 2 beats -> WE never asserts again, outputs at reset values, next command accepted normally.
